// File: rtl/action_scheduler_pkg.sv
// Shared game definitions for the action scheduler: action codes, source
// ordering (bit 0 = highest priority) and the source-to-action mapping.
package action_scheduler_pkg;

    typedef enum logic [3:0] {
        ACT_NONE      = 4'd0,
        ACT_HOLD      = 4'd1,
        ACT_DROP      = 4'd2,
        ACT_ROT_CW    = 4'd3,
        ACT_ROT_CCW   = 4'd4,
        ACT_LEFT      = 4'd5,
        ACT_RIGHT     = 4'd6,
        ACT_SOFT_DOWN = 4'd7,
        ACT_GRAVITY   = 4'd8
    } action_t;

    localparam int NUM_SRC = 8;
    localparam int GRAV_W  = 6;

    // Pending-bit positions, highest priority at bit 0.
    localparam logic [2:0] SRC_HOLD      = 3'd0;
    localparam logic [2:0] SRC_DROP      = 3'd1;
    localparam logic [2:0] SRC_ROT_CW    = 3'd2;
    localparam logic [2:0] SRC_ROT_CCW   = 3'd3;
    localparam logic [2:0] SRC_LEFT      = 3'd4;
    localparam logic [2:0] SRC_RIGHT     = 3'd5;
    localparam logic [2:0] SRC_SOFT_DOWN = 3'd6;
    localparam logic [2:0] SRC_GRAVITY   = 3'd7;

    localparam logic [7:0] MASK_HOLD_DROP = 8'b0000_0011;
    localparam logic [7:0] MASK_SOFT_GRAV = 8'b1100_0000;

    function automatic action_t src_to_action(input logic [2:0] idx);
        case (idx)
            SRC_HOLD:      return ACT_HOLD;
            SRC_DROP:      return ACT_DROP;
            SRC_ROT_CW:    return ACT_ROT_CW;
            SRC_ROT_CCW:   return ACT_ROT_CCW;
            SRC_LEFT:      return ACT_LEFT;
            SRC_RIGHT:     return ACT_RIGHT;
            SRC_SOFT_DOWN: return ACT_SOFT_DOWN;
            SRC_GRAVITY:   return ACT_GRAVITY;
            default:       return ACT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/action_scheduler_prio_encoder8.sv
// Combinational 8-input fixed-priority encoder; bit 0 wins.
module prio_encoder8 (
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] idx,
    output logic       any
);

    // Lowest set request bit selects the grant.
    always_comb begin
        any = |req;
        casez (req)
            8'b???????1: idx = 3'd0;
            8'b??????10: idx = 3'd1;
            8'b?????100: idx = 3'd2;
            8'b????1000: idx = 3'd3;
            8'b???10000: idx = 3'd4;
            8'b??100000: idx = 3'd5;
            8'b?1000000: idx = 3'd6;
            8'b10000000: idx = 3'd7;
            default:     idx = 3'd0;
        endcase
        if (any) begin
            grant = 8'b0000_0001 << idx;
        end else begin
            grant = 8'b0000_0000;
        end
    end

endmodule

// File: rtl/action_scheduler.sv
// Collects player commands and gravity steps into sticky pending bits and
// offers them one at a time, by fixed priority, over a valid/ready port.
module action_scheduler
    import action_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_game,
    input  logic       game_active,
    input  logic       piece_spawn,
    input  logic [5:0] gravity_frames,
    input  logic       cmd_left,
    input  logic       cmd_right,
    input  logic       cmd_down,
    input  logic       cmd_rotate_cw,
    input  logic       cmd_rotate_ccw,
    input  logic       cmd_drop,
    input  logic       cmd_hold,
    output logic       act_valid,
    output logic [3:0] act_code,
    input  logic       act_ready
);

    logic [NUM_SRC-1:0] pending_r;
    logic               hold_used_r;
    logic [GRAV_W-1:0]  grav_cnt_r;

    logic [NUM_SRC-1:0] grant_s;
    logic [2:0]         idx_s;
    logic               any_s;
    logic [NUM_SRC-1:0] cmd_set_s;
    logic [NUM_SRC-1:0] set_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] pending_nxt_s;
    logic [GRAV_W-1:0]  frames_s;
    logic [GRAV_W:0]    grav_inc_s;
    logic [GRAV_W-1:0]  grav_nxt_s;
    logic               grav_hit_s;
    logic               grav_clr_s;
    logic               load_s;
    logic               load_soft_s;
    logic               load_drop_s;
    logic               xfer_s;

    prio_encoder8 u_prio (
        .req   (pending_r),
        .grant (grant_s),
        .idx   (idx_s),
        .any   (any_s)
    );

    // Next pending set, gravity counter and load controls.
    always_comb begin
        xfer_s      = act_valid & act_ready;
        load_s      = ~act_valid | act_ready;
        load_soft_s = load_s & any_s & (idx_s == SRC_SOFT_DOWN);
        load_drop_s = load_s & any_s & (idx_s == SRC_DROP);

        cmd_set_s                = 8'b0000_0000;
        cmd_set_s[SRC_HOLD]      = cmd_hold & ~hold_used_r;
        cmd_set_s[SRC_DROP]      = cmd_drop;
        cmd_set_s[SRC_ROT_CW]    = cmd_rotate_cw;
        cmd_set_s[SRC_ROT_CCW]   = cmd_rotate_ccw;
        cmd_set_s[SRC_LEFT]      = cmd_left & ~cmd_right;
        cmd_set_s[SRC_RIGHT]     = cmd_right & ~cmd_left;
        cmd_set_s[SRC_SOFT_DOWN] = cmd_down;

        if (gravity_frames == 6'd0) begin
            frames_s = 6'd1;
        end else begin
            frames_s = gravity_frames;
        end
        grav_inc_s = {1'b0, grav_cnt_r} + 7'd1;
        grav_hit_s = tick_game & (grav_inc_s >= {1'b0, frames_s});
        grav_clr_s = piece_spawn | load_soft_s;

        // A clear (spawn or soft drop) discards a coincident tick.
        if (grav_clr_s) begin
            grav_nxt_s = 6'd0;
        end else if (grav_hit_s) begin
            grav_nxt_s = 6'd0;
        end else if (tick_game) begin
            grav_nxt_s = grav_inc_s[GRAV_W-1:0];
        end else begin
            grav_nxt_s = grav_cnt_r;
        end

        set_s              = cmd_set_s;
        set_s[SRC_GRAVITY] = grav_hit_s & ~grav_clr_s;

        if (load_s) begin
            clr_s = grant_s;
        end else begin
            clr_s = 8'b0000_0000;
        end
        if (load_drop_s) begin
            clr_s = clr_s | MASK_SOFT_GRAV;
        end else begin
            clr_s = clr_s;
        end

        if (piece_spawn) begin
            pending_nxt_s = cmd_set_s & MASK_HOLD_DROP;
        end else begin
            pending_nxt_s = (pending_r & ~clr_s) | set_s;
        end
    end

    // Pending bits, gravity counter and the registered offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r  <= 8'b0000_0000;
            grav_cnt_r <= 6'd0;
            act_valid  <= 1'b0;
            act_code   <= ACT_NONE;
        end else if (!game_active) begin
            pending_r  <= 8'b0000_0000;
            grav_cnt_r <= 6'd0;
            act_valid  <= 1'b0;
            act_code   <= ACT_NONE;
        end else begin
            pending_r  <= pending_nxt_s;
            grav_cnt_r <= grav_nxt_s;
            if (load_s) begin
                act_valid <= any_s;
                act_code  <= any_s ? src_to_action(idx_s) : ACT_NONE;
            end
        end
    end

    // One hold per piece; survives a game pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_used_r <= 1'b0;
        end else if (piece_spawn) begin
            hold_used_r <= 1'b0;
        end else if (xfer_s && act_code == ACT_HOLD) begin
            hold_used_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_action_scheduler.sv
// Randomized + directed bench for action_scheduler with a queue-based
// scoreboard fed by an array-level reference model.
module tb_action_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_game = 1'b0;
    logic       game_active = 1'b0;
    logic       piece_spawn = 1'b0;
    logic [5:0] gravity_frames = 6'd63;
    logic       cmd_left = 1'b0, cmd_right = 1'b0, cmd_down = 1'b0;
    logic       cmd_rotate_cw = 1'b0, cmd_rotate_ccw = 1'b0;
    logic       cmd_drop = 1'b0, cmd_hold = 1'b0;
    logic       act_valid;
    logic [3:0] act_code;
    logic       act_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int exp_off_q[$];
    int exp_xfer_q[$];
    int seen[0:15];

    // reference model: pend[c] = action code c waiting
    bit m_pend[1:8];
    bit m_hu;
    int m_gc;
    bit m_v;
    int m_code;

    action_scheduler dut (
        .clk(clk), .rst(rst), .tick_game(tick_game), .game_active(game_active),
        .piece_spawn(piece_spawn), .gravity_frames(gravity_frames),
        .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down),
        .cmd_rotate_cw(cmd_rotate_cw), .cmd_rotate_ccw(cmd_rotate_ccw),
        .cmd_drop(cmd_drop), .cmd_hold(cmd_hold),
        .act_valid(act_valid), .act_code(act_code), .act_ready(act_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 1; c <= 8; c++) m_pend[c] = 1'b0;
        m_hu = 1'b0; m_gc = 0; m_v = 1'b0; m_code = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit np[1:8];
        bit old_hu;
        bit soft_load;
        int first;
        int frames;
        exp_off_q.push_back(m_v ? m_code : -1);
        if (rst) begin
            model_reset();
            return;
        end
        if (m_v && act_ready) exp_xfer_q.push_back(m_code);
        old_hu = m_hu;
        if (piece_spawn) m_hu = 1'b0;
        else if (m_v && act_ready && m_code == 1) m_hu = 1'b1;
        if (!game_active) begin
            for (int c = 1; c <= 8; c++) m_pend[c] = 1'b0;
            m_gc = 0; m_v = 1'b0; m_code = 0;
            return;
        end
        np = m_pend;
        soft_load = 1'b0;
        if (!m_v || act_ready) begin
            first = 0;
            for (int c = 1; c <= 8; c++) if (m_pend[c] && first == 0) first = c;
            if (first != 0) begin
                m_v = 1'b1; m_code = first; np[first] = 1'b0;
                if (first == 2) begin np[7] = 1'b0; np[8] = 1'b0; end
                if (first == 7) soft_load = 1'b1;
            end else begin
                m_v = 1'b0; m_code = 0;
            end
        end
        frames = (gravity_frames == 6'd0) ? 1 : int'(gravity_frames);
        if (piece_spawn || soft_load) m_gc = 0;
        else if (tick_game) begin
            if (m_gc + 1 >= frames) begin m_gc = 0; np[8] = 1'b1; end
            else m_gc = m_gc + 1;
        end
        if (cmd_left && !cmd_right) np[5] = 1'b1;
        if (cmd_right && !cmd_left) np[6] = 1'b1;
        if (cmd_down) np[7] = 1'b1;
        if (cmd_rotate_cw) np[3] = 1'b1;
        if (cmd_rotate_ccw) np[4] = 1'b1;
        if (cmd_drop) np[2] = 1'b1;
        if (cmd_hold && !old_hu) np[1] = 1'b1;
        if (piece_spawn) begin
            for (int c = 1; c <= 8; c++) np[c] = 1'b0;
            np[1] = cmd_hold && !old_hu;
            np[2] = cmd_drop;
        end
        m_pend = np;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk); #1;
        {cmd_left, cmd_right, cmd_down, cmd_rotate_cw, cmd_rotate_ccw, cmd_drop, cmd_hold} = 7'b0;
        tick_game = 1'b0;
        piece_spawn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic int total_seen();
        int s = 0;
        for (int c = 0; c < 16; c++) s += seen[c];
        return s;
    endfunction

    // Monitor: compares every offer and every transfer against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_off_q.size() == 0) chk("offer_q_underflow", 1, 0);
            else chk("offer", act_valid ? int'(act_code) : -1, exp_off_q.pop_front());
            if (act_valid && act_ready && !rst) begin
                if (exp_xfer_q.size() == 0) chk("xfer_extra", int'(act_code), -1);
                else chk("xfer", int'(act_code), exp_xfer_q.pop_front());
                seen[act_code] = seen[act_code] + 1;
            end
        end
    end

    initial begin
        int base;
        for (int c = 0; c < 16; c++) seen[c] = 0;
        @(posedge clk); #1;
        model_reset();
        mon_en = 1'b1;
        idle(2);
        chk("reset_valid", int'(act_valid), 0);
        chk("reset_code", int'(act_code), 0);
        rst = 1'b0;
        game_active = 1'b1;
        act_ready = 1'b1;
        idle(2);

        // single left
        base = seen[5];
        cmd_left = 1'b1; cycle();
        idle(4);
        chk("left_once", seen[5] - base, 1);

        // left + rotate cw
        base = seen[3] + seen[5];
        cmd_left = 1'b1; cmd_rotate_cw = 1'b1; cycle();
        idle(4);
        chk("cw_left_pair", seen[3] + seen[5] - base, 2);

        // stall with RIGHT offered, then higher-priority DROP
        act_ready = 1'b0;
        cmd_right = 1'b1; cycle();
        idle(10);
        cmd_drop = 1'b1; cycle();
        idle(2);
        chk("stall_code", int'(act_code), 6);
        chk("stall_valid", int'(act_valid), 1);
        base = seen[2];
        act_ready = 1'b1;
        idle(4);
        chk("drop_after_stall", seen[2] - base, 1);

        // gravity every 3 frames, then every frame
        piece_spawn = 1'b1; cycle();
        idle(2);
        gravity_frames = 6'd3;
        base = seen[8];
        for (int i = 0; i < 9; i++) begin tick_game = 1'b1; cycle(); idle(1); end
        idle(3);
        chk("gravity_3", seen[8] - base, 3);
        gravity_frames = 6'd0;
        base = seen[8];
        for (int i = 0; i < 4; i++) begin tick_game = 1'b1; cycle(); idle(2); end
        idle(3);
        chk("gravity_0", seen[8] - base, 4);
        gravity_frames = 6'd63;

        // hold once per piece
        piece_spawn = 1'b1; cycle();
        base = seen[1];
        cmd_hold = 1'b1; cycle();
        idle(4);
        cmd_hold = 1'b1; cycle();
        idle(4);
        chk("hold_once", seen[1] - base, 1);
        piece_spawn = 1'b1; cycle();
        cmd_hold = 1'b1; cycle();
        idle(4);
        chk("hold_after_spawn", seen[1] - base, 2);

        // left+right cancel; game_active drop flushes
        base = total_seen();
        cmd_left = 1'b1; cmd_right = 1'b1; cycle();
        idle(3);
        chk("lr_cancel", total_seen() - base, 0);
        act_ready = 1'b0;
        cmd_down = 1'b1; cmd_rotate_ccw = 1'b1; cycle();
        idle(2);
        game_active = 1'b0; cycle();
        chk("flush_valid", int'(act_valid), 0);
        game_active = 1'b1;
        act_ready = 1'b1;
        idle(3);
        chk("flush_pending", total_seen() - base, 0);

        // reset during a stalled offer
        act_ready = 1'b0;
        cmd_rotate_cw = 1'b1; cycle();
        idle(2);
        act_ready = 1'b1; rst = 1'b1; cycle();
        rst = 1'b0;
        chk("rst_abort_valid", int'(act_valid), 0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cmd_left       = ($urandom_range(0, 7) == 0);
            cmd_right      = ($urandom_range(0, 7) == 0);
            cmd_down       = ($urandom_range(0, 9) == 0);
            cmd_rotate_cw  = ($urandom_range(0, 9) == 0);
            cmd_rotate_ccw = ($urandom_range(0, 9) == 0);
            cmd_drop       = ($urandom_range(0, 19) == 0);
            cmd_hold       = ($urandom_range(0, 14) == 0);
            tick_game      = ($urandom_range(0, 3) == 0);
            piece_spawn    = ($urandom_range(0, 39) == 0);
            game_active    = ($urandom_range(0, 49) != 0);
            act_ready      = ($urandom_range(0, 9) < 7);
            rst            = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) gravity_frames = 6'($urandom_range(0, 4));
            cycle();
        end
        rst = 1'b0; game_active = 1'b1; act_ready = 1'b1;
        idle(12);
        chk("xfer_q_drained", exp_xfer_q.size(), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/action_scheduler.md
ACTION_SCHEDULER -- requirements
Module: action_scheduler

Interface
REQ-001 clk  in  1  system clock.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 tick_game  in  1  60 Hz frame pulse, one clk wide.
REQ-004 game_active  in  1  piece in play; low = scheduler idle/flush.
REQ-005 piece_spawn  in  1  one-clk pulse when a new piece is spawned.
REQ-006 gravity_frames  in  6  frames per gravity step; 0 treated as 1.
REQ-007 cmd_left, cmd_right, cmd_down, cmd_rotate_cw, cmd_rotate_ccw, cmd_drop, cmd_hold  in  1 each  one-clk command pulses from input_manager.
REQ-008 act_valid  out  1  action offered to game FSM.
REQ-009 act_code  out  4  action_t code, stable while act_valid high.
REQ-010 act_ready  in  1  game FSM accepts the action; transfer = act_valid & act_ready.

Function
REQ-011 One sticky pending bit per source: HOLD, DROP, ROT_CW, ROT_CCW, LEFT, RIGHT, SOFT_DOWN, GRAVITY; a cmd pulse sets its bit at the next edge.
REQ-012 cmd_left and cmd_right pulsed in the same cycle shall cancel: neither bit set.
REQ-013 cmd_hold shall be ignored while hold_used=1; hold_used set on HOLD transfer, cleared on piece_spawn.
REQ-014 Fixed priority, highest first: HOLD, DROP, ROT_CW, ROT_CCW, LEFT, RIGHT, SOFT_DOWN, GRAVITY.
REQ-015 Output register: when act_valid=0 or a transfer occurs this cycle, the highest pending bit (excluding one being transferred) is loaded; act_valid/act_code registered, so pulse at edge k -> act_valid high after edge k+1.
REQ-016 While act_valid=1 and act_ready=0, act_code shall not change, even if higher-priority work arrives.
REQ-017 The pending bit of the loaded action is cleared at load; a new pulse of the same command in the load cycle re-sets it (no pulse lost, no duplicate beyond one pending).
REQ-018 Back-to-back: with act_ready held 1 and N bits pending, one transfer per cycle, N consecutive cycles.
REQ-019 Gravity counter (6-bit) increments on tick_game while game_active; on reaching max(gravity_frames,1) sets GRAVITY pending and returns to 0.
REQ-020 Gravity counter cleared on SOFT_DOWN load and on piece_spawn.
REQ-021 DROP load clears SOFT_DOWN and GRAVITY pending bits.
REQ-022 piece_spawn clears all pending bits except HOLD/DROP pulses in the same cycle, which are kept.
REQ-023 game_active=0: all pending bits, gravity counter, act_valid cleared next edge; cmd pulses ignored; hold_used retained.

Reset
REQ-024 rst: act_valid=0, act_code=ACT_NONE, all pending bits 0, hold_used=0, gravity counter 0.
REQ-025 rst mid-handshake aborts the offered action; no transfer is counted in that cycle.

Structure
REQ-026 action_t (4-bit enum: ACT_NONE=0, ACT_HOLD=1, ACT_DROP=2, ACT_ROT_CW=3, ACT_ROT_CCW=4, ACT_LEFT=5, ACT_RIGHT=6, ACT_SOFT_DOWN=7, ACT_GRAVITY=8) and priority order live in the shared game package.
REQ-027 One sub-module: prio_encoder8 (8-bit request -> one-hot grant + index), combinational.

Verification
REQ-028 cmd_left pulse at cycle 0, act_ready=1 -> act_valid=1, act_code=5 in cycle 2 only.
REQ-029 cmd_left+cmd_rotate_cw same cycle, act_ready=1 -> codes 3 then 5 on consecutive cycles.
REQ-030 act_ready=0 for 10 cycles with code 6 offered, then cmd_drop -> code stays 6 until ready, then 2.
REQ-031 gravity_frames=3, 9 tick_game pulses, act_ready=1 -> exactly 3 ACT_GRAVITY transfers; gravity_frames=0 -> one per tick.
REQ-032 cmd_hold twice without piece_spawn -> one ACT_HOLD; after piece_spawn, cmd_hold -> second ACT_HOLD.
REQ-033 cmd_left+cmd_right same cycle -> no action; game_active drop while act_valid -> act_valid=0 next cycle, pending empty.
